regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised successor to the single-write three-port register file.
- Configurable data width, register count and number of read ports.
- Adds a second, late write-back port for multi-cycle results (mult/div, memory loads).
- Adds a per-register busy scoreboard so the datapath can detect RAW/WAW hazards against in-flight results.
- Sits in the datapath between decode (reads, issue) and write-back (normal and late writes); v0 and r31 taps feed the top-level ports and debug.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH
NUM_READ, 2, number of combinational read ports (1..4)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
ra  input  NUM_READ*ADDR_WIDTH  read addresses, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
rd  output  NUM_READ*DATA_WIDTH  read data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
rd_busy  output  NUM_READ  port k's register has an outstanding late result
we  input  1  normal write enable
wa  input  ADDR_WIDTH  normal write address
wd  input  DATA_WIDTH  normal write data
issue_valid  input  1  request to reserve a register for a late result
issue_dest  input  ADDR_WIDTH  register to reserve
issue_stall  output  1  reservation refused this cycle
cpl_valid  input  1  late result write
cpl_dest  input  ADDR_WIDTH  late result register
cpl_data  input  DATA_WIDTH  late result data
wr_hazard  output  1  one-cycle pulse: normal write dropped
reg_v0  output  DATA_WIDTH  contents of r2
reg_debug  output  DATA_WIDTH  contents of r31

Behaviour:
Reset and register 0
- Reset (sampled at the posedge): all registers 0, all busy bits 0, wr_hazard 0.
- reg_v0 and reg_debug are driven 0 combinationally while reset is high.
- Register 0 always reads 0 and is never busy.
- Writes, issues and completions to register 0 are ignored.

Reads
- Combinational, zero latency. rd_busy[k] = busy[ra[k]].

Normal write
- Takes effect at the posedge when we=1, wa!=0 and busy[wa]=0.
- If busy[wa]=1: write dropped, wr_hazard=1 for the following cycle only.

Issue
- issue_stall = issue_valid & busy[issue_dest] & ~(cpl_valid & cpl_dest==issue_dest), combinational.
- Accepted issue (issue_valid & ~issue_stall & issue_dest!=0) sets busy[issue_dest] at the posedge.

Completion
- cpl_valid with busy[cpl_dest]=1: writes cpl_data and clears busy[cpl_dest].
- cpl_valid with busy[cpl_dest]=0: ignored (spurious).

Simultaneous events, same cycle
- Completion and accepted issue to the same register: data written, busy stays 1 (new reservation wins).
- we and cpl_valid to the same register: completion data written; the normal write is dropped and flagged by wr_hazard, because busy was set.
- we and cpl_valid to different registers: both written.
- we and an accepted issue to the same non-busy register: wd written, then busy set.

Reset mid-operation
- Reset overrides every write, issue and completion in that cycle: all busy bits clear and all registers go to 0.
- Completions arriving after reset are ignored as spurious.

Optional Feature:
Macro REGFILE_SB_BYPASS_EN.
- Defined: read ports forward same-cycle write data, with priority order:
  - an effective completion to ra[k] returns cpl_data and forces rd_busy[k]=0;
  - otherwise an effective normal write to ra[k] returns wd.
  - Register 0 still reads 0.
- Not defined: reads return the pre-edge register contents only; rd_busy reflects pre-edge busy bits.

Test Plan:
- Reset, then we=1 wa=5 wd=32'hDEADBEEF; next cycle ra[0]=5 -> rd port0 = DEADBEEF, rd_busy[0]=0; write wa=0 wd=1 -> ra=0 reads 0.
- issue_valid dest=8; next cycle ra[1]=8 -> rd_busy[1]=1; cpl_valid dest=8 data=32'h1234 -> following cycle rd=0x1234, rd_busy=0.
- dest 8 busy, issue_valid dest=8 without completion -> issue_stall=1, busy unchanged. With cpl_valid dest=8 in the same cycle -> issue_stall=0, busy stays 1, r8=cpl_data.
- dest 9 busy, we=1 wa=9 wd=7 -> r9 unchanged, wr_hazard=1 for one cycle then 0; cpl_valid dest=10 (not busy) -> r10 unchanged.
- Write r2=0x55 and r31=0xAA -> reg_v0=0x55, reg_debug=0xAA. Assert reset with dest 3 busy and cpl_valid dest=3 -> r3=0, busy clear, reg_v0=reg_debug=0 during reset.
- With REGFILE_SB_BYPASS_EN: we wa=4 wd=0x77 and ra=4 in the same cycle -> rd=0x77 combinationally. Without the macro -> rd=old r4.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a second (late) write-back
// port and a per-register busy scoreboard for in-flight results.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   ra / rd / rd_busy NUM_READ combinational read ports (address, data, busy)
//   we / wa / wd      normal write-back port; dropped if the target is busy
//   issue_*           reserve a register for a late result (sets busy)
//   cpl_*             late result write; clears busy of the target
//   wr_hazard         one-cycle pulse after a normal write was dropped
//   reg_v0, reg_debug taps of r2 and the top register (r31), 0 during reset
//
// Optional build macro REGFILE_SB_BYPASS_EN: read ports forward same-cycle
// completion data (highest priority) or normal write data.
module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          wa,
    input  logic [DATA_WIDTH-1:0]          wd,
    input  logic                           issue_valid,
    input  logic [ADDR_WIDTH-1:0]          issue_dest,
    output logic                           issue_stall,
    input  logic                           cpl_valid,
    input  logic [ADDR_WIDTH-1:0]          cpl_dest,
    input  logic [DATA_WIDTH-1:0]          cpl_data,
    output logic                           wr_hazard,
    output logic [DATA_WIDTH-1:0]          reg_v0,
    output logic [DATA_WIDTH-1:0]          reg_debug
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;

    logic cpl_eff;
    logic we_eff;
    logic we_drop;
    logic issue_acc;

    // busy[0] is never set, so r0 can never complete, stall or drop a write.
    always_comb begin
        cpl_eff     = cpl_valid && (cpl_dest != '0) && busy[cpl_dest];
        we_eff      = we && (wa != '0) && !busy[wa];
        we_drop     = we && (wa != '0) && busy[wa];
        // A completion to the same register frees the slot in this cycle.
        issue_stall = issue_valid && busy[issue_dest]
                      && !(cpl_valid && (cpl_dest == issue_dest));
        issue_acc   = issue_valid && !issue_stall && (issue_dest != '0);
    end

    // we_eff and cpl_eff can never target the same register (one needs busy
    // clear, the other busy set), so the two data writes never collide.
    // Clear-on-completion precedes set-on-issue: a fresh reservation wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            wr_hazard <= 1'b0;
        end else begin
            wr_hazard <= we_drop;
            if (we_eff) begin
                regs[wa] <= wd;
            end
            if (cpl_eff) begin
                regs[cpl_dest] <= cpl_data;
                busy[cpl_dest] <= 1'b0;
            end
            if (issue_acc) begin
                busy[issue_dest] <= 1'b1;
            end
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] addr;
        rd      = '0;
        rd_busy = '0;
        addr    = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            addr = ra[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (addr != '0) begin
                rd[k*DATA_WIDTH +: DATA_WIDTH] = regs[addr];
                rd_busy[k]                     = busy[addr];
`ifdef REGFILE_SB_BYPASS_EN
                if (cpl_eff && (cpl_dest == addr)) begin
                    rd[k*DATA_WIDTH +: DATA_WIDTH] = cpl_data;
                    rd_busy[k]                     = 1'b0;
                end else if (we_eff && (wa == addr)) begin
                    rd[k*DATA_WIDTH +: DATA_WIDTH] = wd;
                end
`endif
            end
        end
    end

    assign reg_v0    = reset ? '0 : regs[2];
    assign reg_debug = reset ? '0 : regs[NUM_REGS-1];

endmodule
